// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed/unsigned multiply-divide holding the HI/LO registers
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             unsigned_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, prod;
    logic [WIDTH-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d, ma, mb, addend, q, r;
    logic               div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
    logic               done_q, done_d, dz_q, dz_d, start, sa, sb;
    logic [WIDTH:0]     sum, rsh, diff;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end
    always_comb begin
        start   = start_mult | start_div;
        state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                  state_q == RUN  ? (cnt_q == 6'(ITER - 1) ? FINISH : RUN) : IDLE;
    end
    // m_q holds the operand consumed every iteration; the other one lives in the low half of acc_q
    always_comb begin
        sa     = !unsigned_op && a[WIDTH-1];
        sb     = !unsigned_op && b[WIDTH-1];
        ma     = sa ? -a : a;
        mb     = sb ? -b : b;
        addend = acc_q[0] ? m_q : '0;
        sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        rsh    = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = rsh - {1'b0, m_q};
        prod   = neg_q ? -acc_q : acc_q;
        q      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        r      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        if (state_q == IDLE && start) begin
            cnt_d     = '0;
            div_d     = !start_mult;
            neg_d     = sa ^ sb;
            neg_rem_d = sa;
            zero_d    = b == '0;
            m_d       = start_mult ? ma : mb;
            acc_d     = {{WIDTH{1'b0}}, start_mult ? mb : ma};
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 6'd1;
            acc_d = div_q ? {diff[WIDTH] ? rsh[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], !diff[WIDTH]}
                          : {sum, acc_q[WIDTH-1:1]};
        end else if (state_q == FINISH) begin
            hi_d = !div_q ? prod[2*WIDTH-1:WIDTH] : zero_q ? hi_q : r;
            lo_d = !div_q ? prod[WIDTH-1:0] : zero_q ? lo_q : q;
        end
    end
    always_comb begin
        busy     = state_q != IDLE;
        done_d   = state_q == FINISH;
        dz_d     = state_q == FINISH && div_q && zero_q;
        done     = done_q;
        div_zero = dz_q;
        hi       = hi_q;
        lo       = lo_q;
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench against a plain-arithmetic HI/LO model
module tb_mult_div_unit;
    logic        clk = 1'b0, rst = 1'b1, start_mult = 1'b0, start_div = 1'b0, unsigned_op = 1'b0;
    logic [31:0] a = '0, b = '0, hi, lo;
    logic        busy, done, div_zero;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    int          checks = 0, fails = 0;

    mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk), .rst(rst), .start_mult(start_mult), .start_div(start_div),
        .unsigned_op(unsigned_op), .a(a), .b(b), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic run_op(input logic sm, input logic sd, input logic u, input logic [31:0] ta,
                          input logic [31:0] tb_, input int poke, input int abrt);
        longint sx, sy, p, qq, rr;
        logic   exp_dz, seen, aborted;
        int     lat;
        exp_dz = 1'b0;
        if (sm) begin
            sx = u ? longint'({32'b0, ta}) : longint'($signed(ta));
            sy = u ? longint'({32'b0, tb_}) : longint'($signed(tb_));
            p  = sx * sy;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (tb_ == 0) begin
            exp_dz = 1'b1;
        end else begin
            sx = u ? longint'({32'b0, ta}) : longint'($signed(ta));
            sy = u ? longint'({32'b0, tb_}) : longint'($signed(tb_));
            qq = sx / sy;
            rr = sx % sy;
            exp_hi = rr[31:0];
            exp_lo = qq[31:0];
        end
        @(negedge clk);
        start_mult = sm; start_div = sd; unsigned_op = u; a = ta; b = tb_;
        @(posedge clk); #1;
        start_mult = 1'b0; start_div = 1'b0;
        a = $urandom; b = $urandom; unsigned_op = 1'($urandom);
        chk("busy_after_start", busy, 1);
        seen = 1'b0; aborted = 1'b0; lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            start_div = (n == poke);
            rst = (n == abrt);
            @(posedge clk); #1;
            start_div = 1'b0;
            if (rst) begin
                rst = 1'b0;
                aborted = 1'b1;
                exp_hi = '0; exp_lo = '0;
                chk("abort_busy", busy, 0);
                chk("abort_hi", hi, 0);
                chk("abort_lo", lo, 0);
            end else if (done) begin
                seen = 1'b1;
                lat = n;
            end
        end
        if (aborted) begin
            chk("abort_no_done", seen, 0);
        end else begin
            chk("latency", lat, 33);
            chk("hi", hi, exp_hi);
            chk("lo", lo, exp_lo);
            chk("div_zero", div_zero, exp_dz);
            chk("busy_at_done", busy, 0);
            @(posedge clk); #1;
            chk("done_cleared", done, 0);
            chk("dz_cleared", div_zero, 0);
        end
    endtask

    initial begin
        start_mult = 1'b1; a = 32'd3; b = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start_mult = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_no_start", busy, 0);
        run_op(1, 0, 0, 32'hFFFFFFFE, 32'h3, -1, -1);
        run_op(0, 1, 0, 32'h5, 32'h0, -1, -1);
        chk("dz_kept_hi", hi, 32'hFFFFFFFF);
        chk("dz_kept_lo", lo, 32'hFFFFFFFA);
        run_op(1, 0, 1, 32'hFFFFFFFF, 32'h2, -1, -1);
        chk("multu_hi", hi, 32'h1);
        run_op(0, 1, 0, 32'hFFFFFFF9, 32'h2, -1, -1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        run_op(0, 1, 0, 32'h80000000, 32'hFFFFFFFF, -1, -1);
        chk("ovf_lo", lo, 32'h80000000);
        run_op(0, 1, 1, 32'hFFFFFFF9, 32'h2, -1, -1);
        chk("divu_lo", lo, 32'h7FFFFFFC);
        run_op(1, 1, 0, 32'h3, 32'h4, -1, -1);
        chk("both_lo", lo, 32'd12);
        run_op(1, 0, 0, $urandom, $urandom, 5, -1);
        run_op(0, 1, 0, $urandom, $urandom, 5, -1);
        run_op(1, 0, 1, $urandom, $urandom, -1, 10);
        for (int i = 0; i < 24; i++) begin
            logic m, u;
            logic [31:0] x, y;
            m = 1'($urandom);
            u = 1'($urandom);
            x = $urandom;
            y = (i % 6 == 5) ? 32'h0 : (i % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom;
            run_op(m, !m, u, x, y, -1, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
